farbborg_system: RTL and testbench

Top-level debug/control block of the farbborg board: a UART command monitor driving eight LEDs and reporting push-button state. It receives 8N1 bytes on `uart_rxd`, parses one- and two-byte commands, and replies on `uart_txd`. `btn[0]` is the board reset; `btn[3:1]` are user inputs readable over UART.

---
 rtl/farbborg_pkg.sv | 35 +++
 rtl/farbborg_uart.sv | 143 ++++++++++++++
 rtl/farbborg_system.sv | 137 +++++++++++++
 tb/tb_farbborg_system.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/farbborg_pkg.sv
// ---------------------------------------------------------------------------
// farbborg_pkg
// Shared constants, parser state type and bit-period helper for the
// farbborg UART command monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package farbborg_pkg;

  // Command bytes recognised by the parser
  localparam logic [7:0] CMD_LED = 8'h4C;  // 'L' + one argument byte
  localparam logic [7:0] CMD_BTN = 8'h42;  // 'B'
  localparam logic [7:0] CMD_VER = 8'h56;  // 'V'

  // Reply bytes
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'
  localparam logic [7:0] PROMPT  = 8'h3E;  // '>'

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ARG = 2'd1,
    ST_REPLY    = 2'd2
  } parse_state_e;

  // Clock cycles per UART bit, truncated
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/farbborg_uart.sv
// ---------------------------------------------------------------------------
// farbborg_uart
// 8N1 receive and transmit engines. RX expects an already synchronised line
// and emits a one-cycle valid strobe per good byte; TX accepts a byte while
// not busy and drives a registered serial output.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module farbborg_uart #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o,
  output logic       txd_o
);

  localparam int unsigned CW   = $clog2(DIV + 1);
  localparam int unsigned HALF = (DIV / 2 > 0) ? DIV / 2 : 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  rx_state_e       rx_state_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            rx_prev_q;

  logic [CW-1:0]   tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic [9:0]      tx_shift_q;
  logic            tx_busy_q;
  logic            txd_q;

  // RX: falling-edge start detect, half-bit glitch recheck, centre sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_prev_q  <= rxd_i;
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rxd_i) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CW'(HALF - 1)) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            // A line that is high again at mid start bit was a glitch
            rx_state_q <= rxd_i ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CW'(DIV - 1)) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_i, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: begin
          if (rx_cnt_q == CW'(DIV - 1)) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            // Low stop bit: framing error, byte dropped without notice
            if (rxd_i) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= rx_shift_q;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // TX: load start/data/stop frame and shift it out LSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_busy_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else if (!tx_busy_q) begin
      if (tx_start_i) begin
        tx_shift_q <= {1'b1, tx_data_i, 1'b0};
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
        tx_busy_q  <= 1'b1;
        txd_q      <= 1'b0;
      end
    end else if (tx_cnt_q == CW'(DIV - 1)) begin
      tx_cnt_q <= '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
        txd_q     <= 1'b1;
      end else begin
        tx_bit_q   <= tx_bit_q + 1'b1;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        txd_q      <= tx_shift_q[1];
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_busy_o  = tx_busy_q;
  assign txd_o      = txd_q;

endmodule

`default_nettype wire

// File: rtl/farbborg_system.sv
// ---------------------------------------------------------------------------
// farbborg_system
// UART command monitor: synchronisers, command parser, LED register and
// optional heartbeat on led[7]. Optional feature macro:
// FARBBORG_HEARTBEAT_EN (led[7] blinks at 1 Hz from a free-running counter).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module farbborg_system #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter logic [7:0]  VERSION  = 8'h01
) (
  input  logic       clk,
  input  logic [3:0] btn,
  output logic [7:0] led,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  import farbborg_pkg::*;

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

  logic         rst;
  logic         rxd_meta_q, rxd_sync_q;
  logic [2:0]   btn_meta_q, btn_sync_q;
  parse_state_e state_q;
  logic [7:0]   reply_q;
  logic [7:0]   led_q;
  logic         prompt_q;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         tx_busy;
  logic         tx_start;
  logic [7:0]   tx_data;

  assign rst = btn[0];

  // Two-flop synchronisers; RX idles high, buttons idle low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      btn_meta_q <= 3'b000;
      btn_sync_q <= 3'b000;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      btn_meta_q <= btn[3:1];
      btn_sync_q <= btn_meta_q;
    end
  end

  // The pending prompt takes precedence over a parser reply
  assign tx_start = !tx_busy && (prompt_q || (state_q == ST_REPLY));
  assign tx_data  = prompt_q ? PROMPT : reply_q;

  // Command parser, LED register and one-shot prompt after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      reply_q  <= 8'h00;
      led_q    <= 8'h00;
      prompt_q <= 1'b1;
    end else begin
      if (tx_start && prompt_q) prompt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            state_q <= ST_REPLY;
            case (rx_data)
              CMD_LED: state_q <= ST_WAIT_ARG;
              CMD_BTN: reply_q <= {5'b00000, btn_sync_q};
              CMD_VER: reply_q <= VERSION;
              default: reply_q <= RSP_ERR;
            endcase
          end
        end
        ST_WAIT_ARG: begin
          if (rx_valid) begin
            led_q   <= rx_data;
            reply_q <= RSP_OK;
            state_q <= ST_REPLY;
          end
        end
        ST_REPLY: begin
          if (!tx_busy && !prompt_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  farbborg_uart #(
    .DIV(DIV)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .rxd_i     (rxd_sync_q),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .tx_data_i (tx_data),
    .tx_start_i(tx_start),
    .tx_busy_o (tx_busy),
    .txd_o     (uart_txd)
  );

`ifdef FARBBORG_HEARTBEAT_EN
  localparam int unsigned HB_HALF = (CLK_FREQ / 2 > 0) ? CLK_FREQ / 2 : 1;
  localparam int unsigned HBW     = $clog2(HB_HALF + 1);

  logic [HBW-1:0] hb_cnt_q;
  logic           hb_q;

  // Free-running half-second counter toggling the heartbeat LED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (hb_cnt_q == HBW'(HB_HALF - 1)) begin
      hb_cnt_q <= '0;
      hb_q     <= ~hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q + 1'b1;
    end
  end

  assign led = {hb_q, led_q[6:0]};
`else
  assign led = led_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_farbborg_system.sv
// ---------------------------------------------------------------------------
// tb_farbborg_system
// Randomised command traffic against a byte-level reference of the command
// protocol, plus directed reset, framing-error and mid-frame reset cases.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_farbborg_system;

  localparam int unsigned CLK_FREQ = 200;
  localparam int unsigned BAUD     = 20;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;
  localparam logic [7:0]  VERSION  = 8'h01;
`ifdef FARBBORG_HEARTBEAT_EN
  localparam logic [7:0]  LED_MASK = 8'h7F;
`else
  localparam logic [7:0]  LED_MASK = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic [3:0] btn;
  logic [7:0] led;
  logic       uart_rxd;
  logic       uart_txd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_led;

  always #5 clk = ~clk;

  farbborg_system #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .VERSION (VERSION)
  ) dut (
    .clk     (clk),
    .btn     (btn),
    .led     (led),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one 8N1 frame; stop_ok=0 forces a framing error
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  // Wait up to budget clocks for a start bit, then sample the frame at bit centres
  task automatic recv_byte(input int budget, output bit got, output logic [7:0] b,
                           output int lat, output logic stop);
    got  = 1'b0;
    b    = 8'h00;
    lat  = 0;
    stop = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        got = 1'b1;
        lat = i + 1;
        break;
      end
    end
    if (got) begin
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (DIV) @(negedge clk);
      stop = uart_txd;
    end
  endtask

  // Reference: reply byte for a command, and LED effect of an 'L' command
  function automatic logic [7:0] expected_reply(input logic [7:0] cmd, input logic [2:0] buttons);
    if (cmd == 8'h4C)      return 8'h4B;
    else if (cmd == 8'h42) return {5'b0, buttons};
    else if (cmd == 8'h56) return VERSION;
    else                   return 8'h3F;
  endfunction

  // Send a command (plus argument for 'L') and check the single reply and LEDs
  task automatic run_cmd(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    bit         got;
    logic [7:0] rb;
    int         lat;
    logic       stop;
    logic [7:0] exp_rep;
    exp_rep = expected_reply(b0, btn[3:1]);
    fork
      begin
        send_byte(b0, 1'b1);
        if (b0 == 8'h4C) begin
          chk({tag, "_led_hold"}, led & LED_MASK, model_led & LED_MASK);
          send_byte(b1, 1'b1);
        end
      end
      recv_byte(30 * DIV, got, rb, lat, stop);
    join
    if (b0 == 8'h4C) model_led = b1;
    chk({tag, "_got"}, got, 1);
    chk({tag, "_reply"}, rb, exp_rep);
    chk({tag, "_stop"}, stop, 1'b1);
    chk({tag, "_led"}, led & LED_MASK, model_led & LED_MASK);
  endtask

  // Pulse reset and check the prompt that follows
  task automatic reset_and_prompt(input string tag);
    bit         got;
    logic [7:0] rb;
    int         lat;
    logic       stop;
    btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_rst_led"}, led, 8'h00);
    chk({tag, "_rst_txd"}, uart_txd, 1'b1);
    btn[0] = 1'b0;
    model_led = 8'h00;
    recv_byte(10 * DIV + 2, got, rb, lat, stop);
    chk({tag, "_prompt_got"}, got, 1);
    chk({tag, "_prompt"}, rb, 8'h3E);
    chk({tag, "_prompt_lat"}, (lat <= 2), 1);
    chk({tag, "_prompt_stop"}, stop, 1'b1);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    bit         got;
    logic [7:0] rb;
    int         lat;
    logic       stop;
    logic [7:0] b;
    int         kind;

    btn       = 4'b0001;
    uart_rxd  = 1'b1;
    model_led = 8'h00;

    reset_and_prompt("init");

    // Directed commands
    run_cmd("led_a5", 8'h4C, 8'hA5);
    btn[3:1] = 3'b101;
    repeat (4) @(negedge clk);
    run_cmd("btn_101", 8'h42, 8'h00);
    run_cmd("ver", 8'h56, 8'h00);
    run_cmd("unk_00", 8'h00, 8'h00);

    // Framing error on 'L': no reply, parser stays idle
    fork
      send_byte(8'h4C, 1'b0);
      recv_byte(15 * DIV, got, rb, lat, stop);
    join
    chk("frame_noreply", got, 0);
    chk("frame_led", led & LED_MASK, model_led & LED_MASK);
    run_cmd("frame_ver", 8'h56, 8'h00);

    // Random traffic
    for (int n = 0; n < 12; n++) begin
      btn[3:1] = 3'($urandom);
      repeat (4) @(negedge clk);
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: run_cmd("rnd_led", 8'h4C, 8'($urandom));
        1: run_cmd("rnd_btn", 8'h42, 8'h00);
        2: run_cmd("rnd_ver", 8'h56, 8'h00);
        default: begin
          b = 8'($urandom);
          while (b == 8'h4C || b == 8'h42 || b == 8'h56) b = 8'($urandom);
          run_cmd("rnd_unk", b, 8'h00);
        end
      endcase
    end

    // Reset during TX data: reply 0x00 keeps the line low through the data bits
    run_cmd("pre_rst_led", 8'h4C, 8'h3C);
    btn[3:1] = 3'b000;
    repeat (4) @(negedge clk);
    fork
      send_byte(8'h42, 1'b1);
      begin
        recv_byte(0, got, rb, lat, stop);
        got = 1'b0;
        for (int i = 0; i < 30 * DIV; i++) begin
          @(negedge clk);
          if (uart_txd === 1'b0) begin
            got = 1'b1;
            break;
          end
        end
        chk("midrst_start", got, 1);
        repeat (DIV / 2 + 4 * DIV) @(negedge clk);
        chk("midrst_txd_low", uart_txd, 1'b0);
        btn[0] = 1'b1;
        #1;
        chk("midrst_txd_async", uart_txd, 1'b1);
        chk("midrst_led_async", led, 8'h00);
        @(negedge clk);
        btn[0] = 1'b0;
        reset_and_prompt("midrst");
      end
    join
    run_cmd("post_rst_ver", 8'h56, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
